fetch_queue: RTL and testbench

- 2-wide instruction buffer between INSTRUCTION_ROM and DECODE in the dual-issue front end.
- Absorbs instruction pairs from the ROM and tags each instruction with its PC.
- Presents the two oldest instructions to DECODE in program order.
- Throttles the ROM enable and supports a single-cycle flush on redirect.

---
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: ROM-side enqueue, decode-side dequeue and status.
// Parameterised by DEPTH so o_count matches the queue occupancy width.
interface fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_flush;
  logic [31:0]      i_redirect_pc;
  logic [0:1][31:0] i_insts;
  logic [1:0]       i_valid;
  logic [1:0]       i_deq;
  logic             o_fetch_en;
  logic [0:1][31:0] o_insts;
  logic [0:1][31:0] o_pcs;
  logic [1:0]       o_valid;
  logic [CW-1:0]    o_count;
  logic             o_overflow;

  modport master (
    output i_flush,
    output i_redirect_pc,
    output i_insts,
    output i_valid,
    output i_deq,
    input  o_fetch_en,
    input  o_insts,
    input  o_pcs,
    input  o_valid,
    input  o_count,
    input  o_overflow
  );

  modport slave (
    input  i_flush,
    input  i_redirect_pc,
    input  i_insts,
    input  i_valid,
    input  i_deq,
    output o_fetch_en,
    output o_insts,
    output o_pcs,
    output o_valid,
    output o_count,
    output o_overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// 2-wide PC-tagging instruction buffer between ROM and decode.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        ovf_q, ovf_d;

  logic        byp;
  logic [1:0]  nenq, nvis, nreq, ndeq;
  logic [1:0]  nbyp, npend, nwr, nadv;
  logic [31:0] e0, e1, w0, pc_w0;
  cnt_t        room;
  logic        drop;
  logic        we0, we1;
  ptr_t        rd_ptr_n1, wr_ptr_n1;

  assign rd_ptr_n1 = rd_ptr_q + 1'b1;
  assign wr_ptr_n1 = wr_ptr_q + 1'b1;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && !bus.i_flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    nenq = {1'b0, bus.i_valid[0]} + {1'b0, bus.i_valid[1]};
    e0   = bus.i_valid[0] ? bus.i_insts[0] : bus.i_insts[1];
    e1   = bus.i_insts[1];
    nvis = (count_q >= cnt_t'(2)) ? 2'd2 : count_q[1:0];
    nreq = (bus.i_deq == 2'd3) ? 2'd2 : bus.i_deq;
    ndeq = (nreq > nvis) ? nvis : nreq;
    // Bypassed slots consumed this cycle never reach storage.
    nbyp  = byp ? ((nreq > nenq) ? nenq : nreq) : 2'd0;
    npend = nenq - nbyp;
    room  = DEPTH_C - count_q + cnt_t'(ndeq);
    drop  = cnt_t'(npend) > room;
    nwr   = drop ? room[1:0] : npend;
    nadv  = nbyp + nwr;
    w0    = (nbyp == 2'd0) ? e0 : e1;
    pc_w0 = pc_next_q + {28'd0, nbyp, 2'b00};
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ptr_t'(nwr);
    rd_ptr_d  = rd_ptr_q + ptr_t'(ndeq);
    count_d   = count_q + cnt_t'(nwr) - cnt_t'(ndeq);
    pc_next_d = pc_next_q + {28'd0, nadv, 2'b00};
    ovf_d     = ovf_q | drop;
    we0       = !bus.i_flush && (nwr != 2'd0);
    we1       = !bus.i_flush && (nwr == 2'd2);
    if (bus.i_flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pc_next_d = bus.i_redirect_pc;
      ovf_d     = ovf_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pc_next_q <= RESET_PC;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pc_next_q <= pc_next_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is left unreset; o_valid masks stale entries.
  always_ff @(posedge i_clk) begin
    if (we0) begin
      inst_mem_q[wr_ptr_q] <= w0;
      pc_mem_q[wr_ptr_q]   <= pc_w0;
    end
    if (we1) begin
      inst_mem_q[wr_ptr_n1] <= e1;
      pc_mem_q[wr_ptr_n1]   <= pc_w0 + 32'd4;
    end
  end

  always_comb begin
    bus.o_insts = '0;
    bus.o_pcs   = '0;
    bus.o_valid = 2'b00;
    if (byp) begin
      if (nenq != 2'd0) begin
        bus.o_insts[0] = e0;
        bus.o_pcs[0]   = pc_next_q;
        bus.o_valid    = 2'b01;
      end
      if (nenq == 2'd2) begin
        bus.o_insts[1] = e1;
        bus.o_pcs[1]   = pc_next_q + 32'd4;
        bus.o_valid    = 2'b11;
      end
    end else begin
      if (count_q != '0) begin
        bus.o_insts[0] = inst_mem_q[rd_ptr_q];
        bus.o_pcs[0]   = pc_mem_q[rd_ptr_q];
        bus.o_valid    = 2'b01;
      end
      if (count_q >= cnt_t'(2)) begin
        bus.o_insts[1] = inst_mem_q[rd_ptr_n1];
        bus.o_pcs[1]   = pc_mem_q[rd_ptr_n1];
        bus.o_valid    = 2'b11;
      end
    end
  end

  // Four free slots leave room for the pair already in flight in the ROM.
  assign bus.o_fetch_en = !bus.i_flush
                        && ((DEPTH_C - count_q) >= cnt_t'(4));
  assign bus.o_count    = count_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model.
// Bypass expectations follow FETCH_QUEUE_BYPASS_EN when defined.
module tb_fetch_queue;
  localparam int DEPTH = 8;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: list of {inst, pc} in program order.
  logic [63:0] mq [$];
  logic [31:0] inq [$];
  logic [31:0] mpc  = 32'h0;
  bit          movf = 1'b0;
  int          nd, req;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      mpc  = 32'h0;
      movf = 1'b0;
    end else if (bus.i_flush) begin
      mq.delete();
      mpc = bus.i_redirect_pc;
    end else begin
      inq.delete();
      for (int s = 0; s < 2; s++)
        if (bus.i_valid[s]) inq.push_back(bus.i_insts[s]);
      req = (int'(bus.i_deq) > 2) ? 2 : int'(bus.i_deq);
      if (BYP && mq.size() == 0) begin
        nd = (req < inq.size()) ? req : inq.size();
        repeat (nd) begin
          void'(inq.pop_front());
          mpc += 32'd4;
        end
      end else begin
        nd = (req < mq.size()) ? req : mq.size();
        repeat (nd) void'(mq.pop_front());
      end
      foreach (inq[k]) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({inq[k], mpc});
          mpc += 32'd4;
        end else begin
          movf = 1'b1;
        end
      end
    end
  end

  logic [31:0] cq [$];
  logic [31:0] xi0, xi1, xp0, xp1;
  logic [1:0]  xv;
  int          ev, c;

  always @(negedge i_clk) begin
    c   = mq.size();
    xi0 = '0; xi1 = '0; xp0 = '0; xp1 = '0;
    if (BYP && c == 0 && !bus.i_flush) begin
      cq.delete();
      for (int s = 0; s < 2; s++)
        if (bus.i_valid[s]) cq.push_back(bus.i_insts[s]);
      ev = cq.size();
      if (ev > 0) begin xi0 = cq[0]; xp0 = mpc; end
      if (ev > 1) begin xi1 = cq[1]; xp1 = mpc + 32'd4; end
    end else begin
      ev = (c > 2) ? 2 : c;
      if (ev > 0) {xi0, xp0} = mq[0];
      if (ev > 1) {xi1, xp1} = mq[1];
    end
    xv = (ev == 2) ? 2'b11 : (ev == 1) ? 2'b01 : 2'b00;
    chk("m_valid", bus.o_valid, xv);
    chk("m_inst0", bus.o_insts[0], xi0);
    chk("m_inst1", bus.o_insts[1], xi1);
    chk("m_pc0", bus.o_pcs[0], xp0);
    chk("m_pc1", bus.o_pcs[1], xp1);
    chk("m_count", bus.o_count, c);
    chk("m_fetch_en", bus.o_fetch_en,
        !bus.i_flush && (DEPTH - c >= 4));
    chk("m_overflow", bus.o_overflow, movf);
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] d,
                       input logic f, input logic [31:0] rpc);
    bus.i_valid       = v;
    bus.i_insts[0]    = a;
    bus.i_insts[1]    = b;
    bus.i_deq         = d;
    bus.i_flush       = f;
    bus.i_redirect_pc = rpc;
  endtask

  task automatic cyc(input logic [1:0] v, input logic [31:0] a,
                     input logic [31:0] b, input logic [1:0] d);
    drive(v, a, b, d, 1'b0, 32'h0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    #1;
  endtask

  initial begin
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    #12;
    chk("rst_valid", bus.o_valid, 2'b00);
    chk("rst_count", bus.o_count, 0);
    chk("rst_fetch_en", bus.o_fetch_en, 1'b1);
    chk("rst_inst0", bus.o_insts[0], 32'h0);
    chk("rst_pc1", bus.o_pcs[1], 32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    cyc(2'b11, 32'hA000_0000, 32'hA000_0001, 2'd0);
    idle();
    chk("t1_valid", bus.o_valid, 2'b11);
    chk("t1_pc0", bus.o_pcs[0], 32'h0);
    chk("t1_pc1", bus.o_pcs[1], 32'h4);
    chk("t1_count", bus.o_count, 2);
    chk("t1_inst0", bus.o_insts[0], 32'hA000_0000);

    cyc(2'b11, 32'hA000_0002, 32'hA000_0003, 2'd0);
    idle();
    chk("fill4_fetch_en", bus.o_fetch_en, 1'b1);
    cyc(2'b11, 32'hA000_0004, 32'hA000_0005, 2'd0);
    idle();
    chk("fill6_fetch_en", bus.o_fetch_en, 1'b0);
    cyc(2'b11, 32'hA000_0006, 32'hA000_0007, 2'd0);
    idle();
    chk("full_count", bus.o_count, 8);
    chk("full_ovf", bus.o_overflow, 1'b0);
    cyc(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 2'd0);
    idle();
    chk("ovf_flag", bus.o_overflow, 1'b1);
    chk("ovf_count", bus.o_count, 8);
    chk("ovf_inst0", bus.o_insts[0], 32'hA000_0000);

    cyc(2'b00, 32'h0, 32'h0, 2'd2);
    cyc(2'b00, 32'h0, 32'h0, 2'd2);
    cyc(2'b00, 32'h0, 32'h0, 2'd1);
    cyc(2'b10, 32'hDEAD_0002, 32'hC000_0000, 2'd2);
    idle();
    chk("mix_count", bus.o_count, 2);
    chk("mix_inst0", bus.o_insts[0], 32'hA000_0007);
    chk("mix_inst1", bus.o_insts[1], 32'hC000_0000);
    chk("mix_pc1", bus.o_pcs[1], 32'h20);

    cyc(2'b11, 32'hD000_0000, 32'hD000_0001, 2'd0);
    cyc(2'b01, 32'hD000_0002, 32'hDEAD_0003, 2'd0);
    drive(2'b11, 32'hE000_0000, 32'hE000_0001, 2'd0, 1'b1, 32'h100);
    #1;
    chk("fl_fetch_en", bus.o_fetch_en, 1'b0);
    @(posedge i_clk);
    #1;
    idle();
    chk("fl_valid", bus.o_valid, 2'b00);
    chk("fl_count", bus.o_count, 0);
    cyc(2'b11, 32'hF000_0000, 32'hF000_0001, 2'd0);
    idle();
    chk("fl_pc0", bus.o_pcs[0], 32'h100);
    chk("fl_pc1", bus.o_pcs[1], 32'h104);

    cyc(2'b11, 32'hB000_0000, 32'hB000_0001, 2'd2);
    cyc(2'b11, 32'hB000_0002, 32'hB000_0003, 2'd2);
    cyc(2'b01, 32'hB000_0004, 32'h0, 2'd2);
    cyc(2'b01, 32'hB000_0005, 32'h0, 2'd1);
    idle();
    chk("wr_count1", bus.o_count, 1);
    chk("wr_pc0", bus.o_pcs[0], 32'h11C);
    cyc(2'b11, 32'hB000_0006, 32'hB000_0007, 2'd0);
    idle();
    chk("wrap_count", bus.o_count, 3);
    chk("wrap_inst0", bus.o_insts[0], 32'hB000_0005);
    chk("wrap_inst1", bus.o_insts[1], 32'hB000_0006);
    chk("wrap_pc1", bus.o_pcs[1], 32'h120);
    cyc(2'b00, 32'h0, 32'h0, 2'd2);
    idle();
    chk("wrap_tail", bus.o_pcs[0], 32'h124);
    cyc(2'b00, 32'h0, 32'h0, 2'd3);
    idle();
    chk("xs_count", bus.o_count, 0);
    chk("xs_valid", bus.o_valid, 2'b00);

`ifdef FETCH_QUEUE_BYPASS_EN
    drive(2'b11, 32'h9000_0000, 32'h9000_0001, 2'd1, 1'b0, 32'h0);
    #1;
    chk("byp_valid", bus.o_valid, 2'b11);
    chk("byp_inst0", bus.o_insts[0], 32'h9000_0000);
    chk("byp_pc0", bus.o_pcs[0], 32'h128);
    @(posedge i_clk);
    #1;
    idle();
    chk("byp_count", bus.o_count, 1);
    chk("byp_left", bus.o_insts[0], 32'h9000_0001);
    chk("byp_left_pc", bus.o_pcs[0], 32'h12C);
`else
    drive(2'b11, 32'h9000_0000, 32'h9000_0001, 2'd1, 1'b0, 32'h0);
    #1;
    chk("nb_valid", bus.o_valid, 2'b00);
    @(posedge i_clk);
    #1;
    idle();
    chk("nb_count", bus.o_count, 2);
    chk("nb_inst0", bus.o_insts[0], 32'h9000_0000);
    chk("nb_pc0", bus.o_pcs[0], 32'h128);
`endif

    cyc(2'b11, 32'h8000_0000, 32'h8000_0001, 2'd0);
    idle();
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("arst_count", bus.o_count, 0);
    chk("arst_valid", bus.o_valid, 2'b00);
    chk("arst_ovf", bus.o_overflow, 1'b0);
    chk("arst_fetch_en", bus.o_fetch_en, 1'b1);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    cyc(2'b11, 32'h7000_0000, 32'h7000_0001, 2'd0);
    idle();
    chk("post_pc0", bus.o_pcs[0], 32'h0);
    chk("post_count", bus.o_count, 2);

    repeat (2) @(posedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
